// File: rtl/ped64_sched_pkg.sv
// Shared types, defaults and the round-robin search helper for the ped64 config scheduler.
package ped64_sched_pkg;

  localparam int NREQ     = 4;
  localparam int CFG_W    = 200;
  localparam int TMO_W    = 12;
  localparam int TIMEOUT  = 4095;
  localparam int MAX_NREQ = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } sched_state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of req at or above ptr, wrapping at n; widths sized for the largest NREQ.
  function automatic rr_pick_t rr_pick(
    input logic [MAX_NREQ-1:0] req,
    input logic [2:0]          ptr,
    input int                  n
  );
    rr_pick_t r;
    int       k;
    r = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      k = (int'(ptr) + i) % n;
      if (!r.found && (i < n) && req[3'(k)]) begin
        r.found = 1'b1;
        r.idx   = 3'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ped64_rr_arb.sv
// Round-robin picker: combinational grant search from a registered priority pointer
// that moves just past the last served requester when upd is pulsed.
module ped64_rr_arb #(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic                    upd,
  input  logic [$clog2(NREQ)-1:0] last_id,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] gnt_id
);
  import ped64_sched_pkg::*;

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] ptr;
  rr_pick_t      pick;

  always_comb begin
    pick   = rr_pick(MAX_NREQ'(req), 3'(ptr), NREQ);
    found  = pick.found;
    gnt_id = IW'(pick.idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (upd) begin
      ptr <= (last_id == IW'(NREQ - 1)) ? '0 : last_id + 1'b1;
    end
  end

endmodule

// File: rtl/ped64_cfg_sched.sv
// Shares the single ped64 config/command port among NREQ requesters: grant, deliver the
// config word, pulse start, then wait for done or timeout and report back to the requester.
module ped64_cfg_sched #(
  parameter int NREQ    = ped64_sched_pkg::NREQ,
  parameter int CFG_W   = ped64_sched_pkg::CFG_W,
  parameter int TMO_W   = ped64_sched_pkg::TMO_W,
  parameter int TIMEOUT = ped64_sched_pkg::TIMEOUT
) (
  input  logic                    gm_clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*CFG_W-1:0]   req_cfg,
  output logic [NREQ-1:0]         req_ready,
  output logic                    ped_cfg_valid,
  output logic [CFG_W-1:0]        ped_cfg_data,
  input  logic                    ped_cfg_ready,
  output logic                    ped_start,
  input  logic                    ped_done,
  output logic [NREQ-1:0]         job_done,
  output logic [NREQ-1:0]         job_err,
  output logic                    sched_busy,
  output logic [$clog2(NREQ)-1:0] cur_id
);
  import ped64_sched_pkg::*;

  localparam int IW = $clog2(NREQ);

  sched_state_e   state;
  sched_state_e   state_nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic           gnt_found;
  logic [IW-1:0]  gnt_id;
  logic [CFG_W-1:0] sel_cfg;
  logic           resp_now;
  logic           tmo_hit;

  assign resp_now = (state == RESP);
  assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT));

  ped64_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .clk     (gm_clk),
    .rst     (rst),
    .req     (req_valid),
    .upd     (resp_now),
    .last_id (cur_id),
    .found   (gnt_found),
    .gnt_id  (gnt_id)
  );

  always_comb begin
    sel_cfg = req_cfg[int'(gnt_id) * CFG_W +: CFG_W];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_found) state_nxt = LOAD;
      LOAD:    if (ped_cfg_ready) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (ped_done || tmo_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The timeout counter reads the WAIT cycle index, starting at 0 on entry; done beats timeout.
  always_ff @(posedge gm_clk) begin
    if (rst) begin
      state         <= IDLE;
      req_ready     <= '0;
      ped_cfg_valid <= 1'b0;
      ped_cfg_data  <= '0;
      ped_start     <= 1'b0;
      job_done      <= '0;
      job_err       <= '0;
      sched_busy    <= 1'b0;
      cur_id        <= '0;
      tmo_cnt       <= '0;
    end else begin
      state      <= state_nxt;
      sched_busy <= (state_nxt != IDLE);
      req_ready  <= '0;
      ped_start  <= 1'b0;
      job_done   <= '0;
      job_err    <= '0;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            req_ready     <= NREQ'(1) << gnt_id;
            ped_cfg_valid <= 1'b1;
            ped_cfg_data  <= sel_cfg;
            cur_id        <= gnt_id;
          end
        end
        LOAD: begin
          if (ped_cfg_ready) begin
            ped_cfg_valid <= 1'b0;
            ped_start     <= 1'b1;
          end
        end
        START: begin
          tmo_cnt <= '0;
        end
        WAIT: begin
          if (ped_done) begin
            job_done <= NREQ'(1) << cur_id;
          end else if (tmo_hit) begin
            job_err <= NREQ'(1) << cur_id;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ped64_cfg_sched.sv
// Directed plus randomized bench for ped64_cfg_sched against a job-level reference model.
module tb_ped64_cfg_sched;

  localparam int NREQ    = 4;
  localparam int W       = 200;
  localparam int TMO_W   = 12;
  localparam int TIMEOUT = 20;

  logic              gm_clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_cfg;
  logic [NREQ-1:0]   req_ready;
  logic              ped_cfg_valid;
  logic [W-1:0]      ped_cfg_data;
  logic              ped_cfg_ready;
  logic              ped_start;
  logic              ped_done;
  logic [NREQ-1:0]   job_done;
  logic [NREQ-1:0]   job_err;
  logic              sched_busy;
  logic [1:0]        cur_id;

  int checks;
  int errors;
  int rr;

  ped64_cfg_sched #(
    .NREQ    (NREQ),
    .CFG_W   (W),
    .TMO_W   (TMO_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .gm_clk        (gm_clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_cfg       (req_cfg),
    .req_ready     (req_ready),
    .ped_cfg_valid (ped_cfg_valid),
    .ped_cfg_data  (ped_cfg_data),
    .ped_cfg_ready (ped_cfg_ready),
    .ped_start     (ped_start),
    .ped_done      (ped_done),
    .job_done      (job_done),
    .job_err       (job_err),
    .sched_busy    (sched_busy),
    .cur_id        (cur_id)
  );

  initial gm_clk = 1'b0;
  always #5 gm_clk = ~gm_clk;

  task automatic tick();
    @(posedge gm_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    return NREQ'(1) << i;
  endfunction

  // Spec rule: first requesting index found scanning upward from the pointer with wrap.
  function automatic int model_pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] rand_cfg();
    logic [223:0] r;
    for (int i = 0; i < 7; i++) r[i*32 +: 32] = $urandom;
    return r[W-1:0];
  endfunction

  task automatic rand_all_cfg();
    for (int i = 0; i < NREQ; i++) req_cfg[i*W +: W] = rand_cfg();
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_req_ready"}, W'(req_ready), '0);
    chk({t, "_cfg_valid"}, W'(ped_cfg_valid), '0);
    chk({t, "_cfg_data"}, ped_cfg_data, '0);
    chk({t, "_start"}, W'(ped_start), '0);
    chk({t, "_job_done"}, W'(job_done), '0);
    chk({t, "_job_err"}, W'(job_err), '0);
    chk({t, "_busy"}, W'(sched_busy), '0);
    chk({t, "_cur_id"}, W'(cur_id), '0);
  endtask

  task automatic reset_dut(input string t);
    rst = 1'b1;
    req_valid = '0;
    ped_done = 1'b0;
    ped_cfg_ready = 1'b0;
    tick();
    rst = 1'b0;
    rr = 0;
    chk_zero(t);
  endtask

  // One job, called with the DUT idle and req_valid already set up.
  // dly: WAIT index carrying ped_done (outside 0..TIMEOUT means never); abort_w: reset at that WAIT index.
  task automatic do_job(input string t, input int exp_g, input int bp, input int dly,
                        input bit keep, input bit junk, input int abort_w);
    logic [W-1:0] exp_cfg;
    int  last;
    bit  is_done;
    exp_cfg = req_cfg[exp_g*W +: W];
    tick();
    chk({t, "_grant"}, W'(req_ready), W'(onehot(exp_g)));
    chk({t, "_cur_id"}, W'(cur_id), W'(exp_g));
    chk({t, "_cfg_valid"}, W'(ped_cfg_valid), W'(1'b1));
    chk({t, "_cfg_data"}, ped_cfg_data, exp_cfg);
    chk({t, "_busy"}, W'(sched_busy), W'(1'b1));
    if (!keep) begin
      req_valid[exp_g] = 1'b0;
      req_cfg[exp_g*W +: W] = rand_cfg();
    end
    for (int b = 0; b < bp; b++) begin
      ped_cfg_ready = 1'b0;
      ped_done = junk ? 1'($urandom % 2) : 1'b0;
      tick();
      chk({t, "_bp_valid"}, W'(ped_cfg_valid), W'(1'b1));
      chk({t, "_bp_data"}, ped_cfg_data, exp_cfg);
      chk({t, "_bp_ready_once"}, W'(req_ready), '0);
      chk({t, "_bp_start"}, W'(ped_start), '0);
    end
    ped_cfg_ready = 1'b1;
    ped_done = junk ? 1'($urandom % 2) : 1'b0;
    tick();
    chk({t, "_start"}, W'(ped_start), W'(1'b1));
    chk({t, "_valid_drop"}, W'(ped_cfg_valid), '0);
    ped_cfg_ready = 1'($urandom % 2);
    ped_done = junk ? 1'($urandom % 2) : 1'b0;
    tick();
    chk({t, "_start_once"}, W'(ped_start), '0);
    is_done = (dly >= 0) && (dly <= TIMEOUT);
    last = is_done ? dly : TIMEOUT;
    for (int w = 0; w <= last; w++) begin
      chk({t, "_wait_quiet"}, W'(job_done | job_err), '0);
      if (w == abort_w) begin
        rst = 1'b1;
        ped_done = 1'b0;
        tick();
        rst = 1'b0;
        rr = 0;
        chk_zero({t, "_rst"});
        return;
      end
      ped_done = (w == dly);
      tick();
    end
    ped_done = 1'b0;
    chk({t, "_job_done"}, W'(job_done), is_done ? W'(onehot(exp_g)) : '0);
    chk({t, "_job_err"}, W'(job_err), is_done ? '0 : W'(onehot(exp_g)));
    tick();
    chk({t, "_resp_once"}, W'(job_done | job_err), '0);
    chk({t, "_idle_gap"}, W'(sched_busy), '0);
    chk({t, "_idle_ready"}, W'(req_ready), '0);
    rr = (exp_g + 1) % NREQ;
  endtask

  initial begin
    int g;
    int t_g;
    checks = 0;
    errors = 0;
    rr = 0;
    rst = 1'b1;
    req_valid = '0;
    req_cfg = '0;
    ped_cfg_ready = 1'b0;
    ped_done = 1'b0;
    rand_all_cfg();
    repeat (3) tick();
    rst = 1'b0;
    chk_zero("reset");

    // Single job on requester 1, done 10 cycles into WAIT.
    req_valid = 4'b0010;
    g = model_pick(req_valid, rr);
    chk("single_pick_model", W'(g), W'(1));
    do_job("single", g, 0, 10, 1'b0, 1'b0, -1);

    // Fairness: everyone requests continuously.
    reset_dut("fair_rst");
    rand_all_cfg();
    req_valid = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      g = model_pick(req_valid, rr);
      do_job("fair", g, 0, 3, 1'b1, 1'b0, -1);
    end

    // Backpressure: ready held low for 7 cycles.
    req_valid = 4'b0001;
    rand_all_cfg();
    do_job("bp", model_pick(req_valid, rr), 7, 5, 1'b0, 1'b0, -1);

    // Timeout with all requesting; the timed-out requester yields priority.
    req_valid = 4'b1111;
    t_g = model_pick(req_valid, rr);
    do_job("tmo", t_g, 0, -1, 1'b1, 1'b0, -1);
    do_job("tmo_next", (t_g + 1) % NREQ, 0, 2, 1'b1, 1'b0, -1);

    // ped_done on the same cycle the counter reaches TIMEOUT: done wins.
    req_valid = 4'b0100;
    do_job("simul", model_pick(req_valid, rr), 1, TIMEOUT, 1'b0, 1'b0, -1);

    // Reset in WAIT after moving the pointer off zero.
    req_valid = 4'b0010;
    do_job("pre_rst", model_pick(req_valid, rr), 0, 1, 1'b0, 1'b0, -1);
    req_valid = 4'b0100;
    do_job("mid_rst", model_pick(req_valid, rr), 0, -1, 1'b0, 1'b1, 4);
    ped_done = 1'b1;
    tick();
    ped_done = 1'b0;
    chk("late_done_quiet", W'(job_done | job_err), '0);
    chk("late_done_busy", W'(sched_busy), '0);
    tick();
    chk("late_done_quiet2", W'(job_done | job_err), '0);
    req_valid = 4'b1010;
    g = model_pick(req_valid, rr);
    chk("post_rst_pick_model", W'(g), W'(1));
    do_job("post_rst", g, 0, 2, 1'b0, 1'b0, -1);
    reset_dut("rst2");
    req_valid = 4'b1000;
    do_job("post_rst3", model_pick(req_valid, rr), 0, 2, 1'b0, 1'b0, -1);

    // Randomized jobs, with stray ped_done while loading.
    for (int j = 0; j < 30; j++) begin
      req_valid = 4'($urandom_range(1, 15));
      rand_all_cfg();
      g = model_pick(req_valid, rr);
      do_job("rand", g, int'($urandom_range(0, 3)), int'($urandom_range(0, 24)), 1'b0, 1'b1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
